axi4_lite_master: RTL and testbench

AXI4-Lite initiator that turns single-beat register commands from local control logic into AXI4-Lite write and read transactions. It is the master-side counterpart of the axi4_lite_if slave. It sits between an internal sequencer (e.g. a filter-coefficient loader or test harness) and the AXI4-Lite slave port of the 2D FIR filter. One transaction is outstanding at a time.

---
 rtl/axi4_lite_pkg.sv | 25 ++
 rtl/axi4_lite_master.sv | 186 ++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared state encodings and AXI response codes for the AXI4-Lite master.
package axi4_lite_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_AW_W = 3'd1;
    localparam logic [2:0] WR_B    = 3'd2;
    localparam logic [2:0] RD_AR   = 3'd3;
    localparam logic [2:0] RD_R    = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = IDLE,
        ST_WR_AW_W = WR_AW_W,
        ST_WR_B    = WR_B,
        ST_RD_AR   = RD_AR,
        ST_RD_R    = RD_R,
        ST_RSP     = RSP
    } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: cmd accept to rsp_valid in 3 cycles with a zero-wait slave;
// cmd_ready only in IDLE, response held until rsp_ready. AXIL_MST_ERR_CNT_EN adds err_cnt/err_clr.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [31:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
`ifdef AXIL_MST_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [15:0]          err_cnt
`endif
);

    state_e                 state_q, state_d;
    logic                   aw_vld_q, aw_vld_d;
    logic                   w_vld_q, w_vld_d;
    logic                   ar_vld_q, ar_vld_d;
    logic [ADDR_BITS-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_BITS-1:0]   araddr_q, araddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic [1:0]             rsp_resp_q, rsp_resp_d;
    logic                   rsp_write_q, rsp_write_d;

    always_comb begin
        state_d     = state_q;
        aw_vld_d    = aw_vld_q;
        w_vld_d     = w_vld_q;
        ar_vld_d    = ar_vld_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d = cmd_addr;
                        wdata_d  = cmd_wdata;
                        wstrb_d  = cmd_wstrb;
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                        state_d  = ST_WR_AW_W;
                    end else begin
                        araddr_d = cmd_addr;
                        ar_vld_d = 1'b1;
                        state_d  = ST_RD_AR;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W retire independently; leave only once both are done.
                if (aw_vld_q && m_axi_awready) aw_vld_d = 1'b0;
                if (w_vld_q && m_axi_wready)   w_vld_d  = 1'b0;
                if (!aw_vld_d && !w_vld_d)     state_d  = ST_WR_B;
            end
            ST_WR_B: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_AR: begin
                if (m_axi_arready) begin
                    ar_vld_d = 1'b0;
                    state_d  = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (m_axi_rvalid) begin
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_write_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            aw_vld_q    <= 1'b0;
            w_vld_q     <= 1'b0;
            ar_vld_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_vld_q    <= aw_vld_d;
            w_vld_q     <= w_vld_d;
            ar_vld_q    <= ar_vld_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RSP);
    assign m_axi_bready  = (state_q == ST_WR_B);
    assign m_axi_rready  = (state_q == ST_RD_R);
    assign m_axi_awvalid = aw_vld_q;
    assign m_axi_wvalid  = w_vld_q;
    assign m_axi_arvalid = ar_vld_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_write     = rsp_write_q;

`ifdef AXIL_MST_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_hit;

    // SLVERR and DECERR both have resp[1] set.
    assign err_hit = (m_axi_bready && m_axi_bvalid && m_axi_bresp[1]) ||
                     (m_axi_rready && m_axi_rvalid && m_axi_rresp[1]);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                           err_cnt_d = '0;
        else if (err_hit && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Randomized bench: a delay-programmable slave memory drives the AXI side, a scoreboard checks responses.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_write;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [31:0] m_axi_rdata = '0;
`ifdef AXIL_MST_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;
    logic [15:0] exp_err = '0;
`endif

    axi4_lite_master #(.ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
`ifdef AXIL_MST_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Address map of the modelled slave: E0..EF -> SLVERR, F0..FF -> DECERR, rest is RAM.
    function automatic logic [1:0] resp_of(input logic [7:0] a);
        if (a >= 8'hF0)      return DECERR;
        else if (a >= 8'hE0) return SLVERR;
        else                 return OKAY;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          acc;
        bit          zw;
        int          drsp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] slv_mem [64];

    int          d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
    logic [7:0]  exp_awaddr = '0, exp_araddr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;

    // ---------------- slave model ----------------
    bit          aw_have, w_have, ar_have;
    bit          awf_p, awp_p, wf_p, wp_p, arf_p, arp_p, bf_p, rf_p;
    bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic [7:0]  la, lra;
    logic [31:0] lw;
    logic [3:0]  ls;

    task automatic slave_clear();
        aw_have = 0; w_have = 0; ar_have = 0;
        awf_p = 0; awp_p = 0; wf_p = 0; wp_p = 0; arf_p = 0; arp_p = 0; bf_p = 0; rf_p = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
    endtask

    initial begin
        logic [1:0] r;
        for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
        slave_clear();
        forever begin
            @(negedge clk);
            if (rst) begin slave_clear(); continue; end
            if (awf_p) check("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
            if (awp_p) check("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
            if (wf_p)  check("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
            if (wp_p)  check("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
            if (arf_p) check("arvalid_drop", 32'(m_axi_arvalid), 32'd0);
            if (arp_p) check("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
            if (bf_p)  check("bready_drop", 32'(m_axi_bready), 32'd0);
            if (rf_p)  check("rready_drop", 32'(m_axi_rready), 32'd0);

            m_axi_awready = 0;
            if (m_axi_awvalid && !aw_have) begin
                if (aw_wait >= d_aw) m_axi_awready = 1; else aw_wait++;
            end
            aw_fire = m_axi_awvalid && m_axi_awready;
            awp_p = m_axi_awvalid && !m_axi_awready;
            awf_p = aw_fire;
            if (aw_fire) begin
                check("awaddr", 32'(m_axi_awaddr), 32'(exp_awaddr));
                la = m_axi_awaddr;
            end

            m_axi_wready = 0;
            if (m_axi_wvalid && !w_have) begin
                if (w_wait >= d_w) m_axi_wready = 1; else w_wait++;
            end
            w_fire = m_axi_wvalid && m_axi_wready;
            wp_p = m_axi_wvalid && !m_axi_wready;
            wf_p = w_fire;
            if (w_fire) begin
                check("wdata", m_axi_wdata, exp_wdata);
                check("wstrb", 32'(m_axi_wstrb), 32'(exp_wstrb));
                lw = m_axi_wdata; ls = m_axi_wstrb;
            end

            if (aw_have && w_have && !m_axi_bvalid) begin
                if (b_wait >= d_b) begin
                    r = resp_of(la);
                    if (r == OKAY) slv_mem[la[7:2]] = merge(slv_mem[la[7:2]], lw, ls);
                    m_axi_bresp = r; m_axi_bvalid = 1;
                end else b_wait++;
            end
            b_fire = m_axi_bvalid && m_axi_bready;
            bf_p = b_fire;

            m_axi_arready = 0;
            if (m_axi_arvalid && !ar_have) begin
                if (ar_wait >= d_ar) m_axi_arready = 1; else ar_wait++;
            end
            ar_fire = m_axi_arvalid && m_axi_arready;
            arp_p = m_axi_arvalid && !m_axi_arready;
            arf_p = ar_fire;
            if (ar_fire) begin
                check("araddr", 32'(m_axi_araddr), 32'(exp_araddr));
                lra = m_axi_araddr;
            end

            if (ar_have && !m_axi_rvalid) begin
                if (r_wait >= d_r) begin
                    r = resp_of(lra);
                    m_axi_rdata = (r == OKAY) ? slv_mem[lra[7:2]] : {24'hBADBAD, lra};
                    m_axi_rresp = r; m_axi_rvalid = 1;
                end else r_wait++;
            end
            r_fire = m_axi_rvalid && m_axi_rready;
            rf_p = r_fire;

            @(posedge clk); #1;
            if (rst) continue;
            if (aw_fire) begin aw_have = 1; m_axi_awready = 0; aw_wait = 0; end
            if (w_fire)  begin w_have = 1; m_axi_wready = 0; w_wait = 0; end
            if (ar_fire) begin ar_have = 1; m_axi_arready = 0; ar_wait = 0; end
            if (b_fire)  begin m_axi_bvalid = 0; aw_have = 0; w_have = 0; b_wait = 0; end
            if (r_fire)  begin m_axi_rvalid = 0; ar_have = 0; r_wait = 0; end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    initial begin
        logic [31:0] f_rdata;
        logic [2:0]  f_meta;
        int          hold;
        bit          seen, after_hs;
        exp_t        e;
        hold = 0; seen = 0; after_hs = 0; f_rdata = '0; f_meta = '0;
        forever begin
            @(negedge clk);
            if (rst) begin rsp_ready = 0; seen = 0; after_hs = 0; hold = 0; continue; end
            if (rsp_valid) begin
                check("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
                if (!seen) begin
                    seen = 1; hold = 0;
                    f_rdata = rsp_rdata; f_meta = {rsp_write, rsp_resp};
                    if (exp_q.size() != 0 && exp_q[0].zw)
                        check("latency", 32'(cyc - exp_q[0].acc), 32'd3);
                end else begin
                    check("rsp_rdata_stable", rsp_rdata, f_rdata);
                    check("rsp_meta_stable", 32'({rsp_write, rsp_resp}), 32'(f_meta));
                end
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    rsp_ready = 1; seen = 0;
                end else if (hold >= exp_q[0].drsp) begin
                    e = exp_q.pop_front();
                    rsp_ready = 1; seen = 0; after_hs = 1;
                    check("rsp_write", 32'(rsp_write), 32'(e.wr));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    if (e.wr && e.resp == OKAY)
                        ref_mem[e.addr[7:2]] = merge(ref_mem[e.addr[7:2]], e.wdata, e.strb);
`ifdef AXIL_MST_ERR_CNT_EN
                    if (e.resp[1] && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
                    check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
                end else begin
                    rsp_ready = 0; hold++;
                end
            end else begin
                if (after_hs) check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
                after_hs = 0; rsp_ready = 0;
            end
        end
    end

    // ---------------- command driver ----------------
    task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int daw, input int dw, input int db, input int dar, input int dr,
                         input int drsp);
        exp_t e;
        int   g;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 0;
            return;
        end
        d_aw = daw; d_w = dw; d_b = db; d_ar = dar; d_r = dr;
        exp_awaddr = a; exp_araddr = a; exp_wdata = d; exp_wstrb = s;
        e.wr = wr; e.addr = a; e.wdata = d; e.strb = s;
        e.resp = resp_of(a);
        e.rdata = wr ? 32'd0 : ((e.resp == OKAY) ? ref_mem[a[7:2]] : {24'hBADBAD, a});
        e.acc = cyc;
        e.zw = (daw == 0 && dw == 0 && db == 0 && dar == 0 && dr == 0);
        e.drsp = drsp;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || rsp_valid) && g < 1000) begin @(negedge clk); g++; end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}), 32'd0);
        check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
        check("rst_araddr", 32'(m_axi_araddr), 32'd0);
        check("rst_wdata", m_axi_wdata, 32'd0);
        check("rst_wstrb", 32'(m_axi_wstrb), 32'd0);
        check("rst_rsp", 32'({rsp_write, rsp_resp}), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
`ifdef AXIL_MST_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk); #3 rst = 0;

        issue(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0); drain();
        issue(1, 8'h14, 32'hCAFEF00D, 4'hF, 4, 0, 0, 0, 0, 0); drain();
        issue(1, 8'h24, 32'h00001234, 4'hF, 0, 0, 0, 0, 0, 0); drain();
        issue(0, 8'h24, 32'h0, 4'h0, 0, 0, 0, 0, 2, 0); drain();
        issue(0, 8'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5); drain();
        issue(1, 8'h10, 32'h11223344, 4'b0101, 0, 3, 1, 0, 0, 0); drain();
        issue(0, 8'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0); drain();
        issue(0, 8'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0); drain();
        for (int i = 0; i < 3; i++) begin
            issue(0, 8'hE4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0); drain();
        end
        issue(1, 8'hF0, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0, 0); drain();
`ifdef AXIL_MST_ERR_CNT_EN
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        @(negedge clk);
        check("err_cnt_clr", 32'(err_cnt), 32'd0);
        exp_err = '0;
`endif

        for (int i = 0; i < 60; i++) begin
            bit         wr, zw;
            logic [7:0] a;
            wr = 1'($urandom);
            a  = 8'($urandom_range(0, 63) << 2);
            zw = ($urandom_range(0, 3) == 0);
            if (zw) issue(wr, a, $urandom, 4'($urandom), 0, 0, 0, 0, 0, $urandom_range(0, 2));
            else    issue(wr, a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
        end
        drain();

        issue(1, 8'h30, 32'hA5A5A5A5, 4'hF, 10, 10, 0, 0, 0, 0);
        #3;
        check("pre_rst_awvalid", 32'(m_axi_awvalid), 32'd1);
        rst = 1;
        #1;
        check("rst_mid_awvalid", 32'(m_axi_awvalid), 32'd0);
        check("rst_mid_wvalid", 32'(m_axi_wvalid), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
`ifdef AXIL_MST_ERR_CNT_EN
        exp_err = '0;
`endif
        @(posedge clk);
        @(posedge clk); #3 rst = 0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        issue(0, 8'h30, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
